multicycle_execute: RTL and testbench

MULTICYCLE_EXECUTE -- requirements
Module: multicycle_execute

---
 rtl/exe_pkg.sv | 34 +++
 rtl/exe_forward_sel.sv | 30 +++
 rtl/multicycle_execute.sv | 246 ++++++++++++++++++++++++
 tb/tb_multicycle_execute.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exe_pkg
// Brief    : Shared decode and forwarding-select constants for the EX stage.
// Revision : 1.0 - initial release
// ============================================================================
package exe_pkg;

  localparam logic [1:0] ALUOP_ADD     = 2'b00;
  localparam logic [1:0] ALUOP_SUB     = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT   = 2'b10;
  localparam logic [1:0] ALUOP_ADD_ILL = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'd0;
  localparam logic [5:0] FUNCT_SUB = 6'd1;
  localparam logic [5:0] FUNCT_AND = 6'd2;
  localparam logic [5:0] FUNCT_OR  = 6'd3;
  localparam logic [5:0] FUNCT_XOR = 6'd4;
  localparam logic [5:0] FUNCT_SLT = 6'd5;
  localparam logic [5:0] FUNCT_SLL = 6'd6;
  localparam logic [5:0] FUNCT_SRL = 6'd7;
  localparam logic [5:0] FUNCT_MUL = 6'd8;

  localparam logic [1:0] FWD_NOMINAL = 2'b00;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

endpackage
`default_nettype wire

// File: rtl/exe_forward_sel.sv
`default_nettype none
// ============================================================================
// Module   : exe_forward_sel
// Brief    : Picks the forwarding source for one operand; EX/MEM wins, r0 never.
// Revision : 1.0 - initial release
// ============================================================================
module exe_forward_sel
  import exe_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  exMemRegWrite_i,
  input  logic [REG_ADDR_W-1:0] exMemRd_i,
  input  logic                  memWbRegWrite_i,
  input  logic [REG_ADDR_W-1:0] memWbRd_i,
  input  logic [REG_ADDR_W-1:0] src_i,
  output logic [1:0]            sel_o
);

  always_comb begin
    sel_o = FWD_NOMINAL;
    if (exMemRegWrite_i && (exMemRd_i != '0) && (exMemRd_i == src_i)) begin
      sel_o = FWD_EXMEM;
    end else if (memWbRegWrite_i && (memWbRd_i != '0) && (memWbRd_i == src_i)) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_execute.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_execute
// Brief    : EX stage with forwarding, ALU and optional iterative multiplier
//            (built when EXECUTE_MUL_EN is defined). State changes on negedge.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_execute
  import exe_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [1:0]            writeBackControlIn,
  input  logic [1:0]            memAccessControlIn,
  input  logic [3:0]            calculationControl,
  input  logic [WIDTH-1:0]      readData1,
  input  logic [WIDTH-1:0]      readData2,
  input  logic [WIDTH-1:0]      immediateOperand,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rdIn,
  input  logic                  memWbRegWrite,
  input  logic [REG_ADDR_W-1:0] memWbRd,
  input  logic [WIDTH-1:0]      memWbData,
  output logic [1:0]            writeBackControlOut,
  output logic [1:0]            memAccessControlOut,
  output logic [WIDTH-1:0]      result,
  output logic [WIDTH-1:0]      writeData,
  output logic [REG_ADDR_W-1:0] rdOut,
  output logic                  stall,
  output logic                  illegalOp
);

  localparam int SHW = $clog2(WIDTH);

  logic [1:0]            wb_q, wb_d, mem_q, mem_d;
  logic [WIDTH-1:0]      result_q, result_d, wdata_q, wdata_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  ill_q, ill_d;

  logic [1:0]            w_sel_rs, w_sel_rt;
  logic [WIDTH-1:0]      w_fwd_rs, w_fwd_rt, w_op2, w_alu_res;
  logic                  w_alu_ill, w_is_mul;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [5:0]            w_funct;
  logic [SHW-1:0]        w_shamt;

  exe_forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
    .exMemRegWrite_i(wb_q[1]), .exMemRd_i(rd_q),
    .memWbRegWrite_i(memWbRegWrite), .memWbRd_i(memWbRd),
    .src_i(rs), .sel_o(w_sel_rs)
  );

  exe_forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
    .exMemRegWrite_i(wb_q[1]), .exMemRd_i(rd_q),
    .memWbRegWrite_i(memWbRegWrite), .memWbRd_i(memWbRd),
    .src_i(rt), .sel_o(w_sel_rt)
  );

  always_comb begin
    case (w_sel_rs)
      FWD_EXMEM: w_fwd_rs = result_q;
      FWD_MEMWB: w_fwd_rs = memWbData;
      default:   w_fwd_rs = readData1;
    endcase
    case (w_sel_rt)
      FWD_EXMEM: w_fwd_rt = result_q;
      FWD_MEMWB: w_fwd_rt = memWbData;
      default:   w_fwd_rt = readData2;
    endcase
  end

  assign w_op2   = calculationControl[0] ? immediateOperand : w_fwd_rt;
  assign w_rd    = calculationControl[3] ? rdIn : rt;
  assign w_funct = immediateOperand[5:0];
  assign w_shamt = w_op2[SHW-1:0];

  always_comb begin
    w_alu_res = '0;
    w_alu_ill = 1'b0;
    w_is_mul  = 1'b0;
    case (calculationControl[2:1])
      ALUOP_ADD: w_alu_res = w_fwd_rs + w_op2;
      ALUOP_SUB: w_alu_res = w_fwd_rs - w_op2;
      ALUOP_FUNCT: begin
        case (w_funct)
          FUNCT_ADD: w_alu_res = w_fwd_rs + w_op2;
          FUNCT_SUB: w_alu_res = w_fwd_rs - w_op2;
          FUNCT_AND: w_alu_res = w_fwd_rs & w_op2;
          FUNCT_OR:  w_alu_res = w_fwd_rs | w_op2;
          FUNCT_XOR: w_alu_res = w_fwd_rs ^ w_op2;
          FUNCT_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(w_fwd_rs) < $signed(w_op2))};
          FUNCT_SLL: w_alu_res = w_fwd_rs << w_shamt;
          FUNCT_SRL: w_alu_res = w_fwd_rs >> w_shamt;
`ifdef EXECUTE_MUL_EN
          FUNCT_MUL: w_is_mul  = 1'b1;
`endif
          default:   w_alu_ill = 1'b1;
        endcase
      end
      default: begin
        w_alu_res = w_fwd_rs + w_op2;
        w_alu_ill = 1'b1;
      end
    endcase
  end

`ifdef EXECUTE_MUL_EN
  localparam int             CW         = $clog2(WIDTH);
  localparam logic [CW-1:0]  c_CNT_LAST = CW'(WIDTH - 1);

  mul_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]      mca_q, mca_d, mpl_q, mpl_d, prod_q, prod_d, cap_wdata_q, cap_wdata_d;
  logic [1:0]            cap_wb_q, cap_wb_d, cap_mem_q, cap_mem_d;
  logic [REG_ADDR_W-1:0] cap_rd_q, cap_rd_d;
  logic [WIDTH-1:0]      w_prod_step;

  // Multiplicand shifts left and multiplier shifts right, one partial product per edge.
  assign w_prod_step = prod_q + (mpl_q[0] ? mca_q : '0);

  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      if (state_q == MUL_IDLE) stall = w_is_mul && !flush;
      else                     stall = (cnt_q != c_CNT_LAST);
    end
  end
`else
  logic w_unused_mul;
  assign w_unused_mul = w_is_mul;
  assign stall        = 1'b0;
`endif

  always_comb begin
    wb_d     = writeBackControlIn;
    mem_d    = memAccessControlIn;
    result_d = w_alu_res;
    wdata_d  = w_fwd_rt;
    rd_d     = w_rd;
    ill_d    = w_alu_ill;
`ifdef EXECUTE_MUL_EN
    state_d     = state_q;
    cnt_d       = cnt_q;
    mca_d       = mca_q;
    mpl_d       = mpl_q;
    prod_d      = prod_q;
    cap_wb_d    = cap_wb_q;
    cap_mem_d   = cap_mem_q;
    cap_wdata_d = cap_wdata_q;
    cap_rd_d    = cap_rd_q;
    if (state_q == MUL_BUSY) begin
      wb_d = '0; mem_d = '0; result_d = '0; wdata_d = '0; rd_d = '0; ill_d = 1'b0;
      prod_d = w_prod_step;
      mca_d  = mca_q << 1;
      mpl_d  = mpl_q >> 1;
      cnt_d  = cnt_q + CW'(1);
      if (cnt_q == c_CNT_LAST) begin
        state_d  = MUL_IDLE;
        wb_d     = cap_wb_q;
        mem_d    = cap_mem_q;
        result_d = w_prod_step;
        wdata_d  = cap_wdata_q;
        rd_d     = cap_rd_q;
      end
    end else if (w_is_mul) begin
      state_d     = MUL_BUSY;
      cnt_d       = '0;
      mca_d       = w_fwd_rs;
      mpl_d       = w_op2;
      prod_d      = '0;
      cap_wb_d    = writeBackControlIn;
      cap_mem_d   = memAccessControlIn;
      cap_wdata_d = w_fwd_rt;
      cap_rd_d    = w_rd;
      wb_d = '0; mem_d = '0; result_d = '0; wdata_d = '0; rd_d = '0; ill_d = 1'b0;
    end
`endif
    if (flush) begin
      wb_d = '0; mem_d = '0; result_d = '0; wdata_d = '0; rd_d = '0; ill_d = 1'b0;
`ifdef EXECUTE_MUL_EN
      state_d = MUL_IDLE;
`endif
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      wb_q     <= '0;
      mem_q    <= '0;
      result_q <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      ill_q    <= 1'b0;
    end else begin
      wb_q     <= wb_d;
      mem_q    <= mem_d;
      result_q <= result_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      ill_q    <= ill_d;
    end
  end

`ifdef EXECUTE_MUL_EN
  always_ff @(negedge clk or posedge reset) begin
    if (reset) state_q <= MUL_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      mca_q       <= '0;
      mpl_q       <= '0;
      prod_q      <= '0;
      cap_wb_q    <= '0;
      cap_mem_q   <= '0;
      cap_wdata_q <= '0;
      cap_rd_q    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      mca_q       <= mca_d;
      mpl_q       <= mpl_d;
      prod_q      <= prod_d;
      cap_wb_q    <= cap_wb_d;
      cap_mem_q   <= cap_mem_d;
      cap_wdata_q <= cap_wdata_d;
      cap_rd_q    <= cap_rd_d;
    end
  end
`endif

  assign writeBackControlOut = wb_q;
  assign memAccessControlOut = mem_q;
  assign result              = result_q;
  assign writeData           = wdata_q;
  assign rdOut               = rd_q;
  assign illegalOp           = ill_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_execute.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_execute
// Brief    : Scoreboard bench for multicycle_execute (MUL scenarios under EXECUTE_MUL_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_execute;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic [1:0]   writeBackControlIn = '0, memAccessControlIn = '0;
  logic [3:0]   calculationControl = '0;
  logic [W-1:0] readData1 = '0, readData2 = '0, immediateOperand = '0;
  logic [4:0]   rs = '0, rt = '0, rdIn = '0;
  logic         memWbRegWrite = 1'b0;
  logic [4:0]   memWbRd = '0;
  logic [W-1:0] memWbData = '0;
  logic [1:0]   writeBackControlOut, memAccessControlOut;
  logic [W-1:0] result, writeData;
  logic [4:0]   rdOut;
  logic         stall, illegalOp;

  multicycle_execute #(.WIDTH(W), .REG_ADDR_W(5)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .writeBackControlIn(writeBackControlIn), .memAccessControlIn(memAccessControlIn),
    .calculationControl(calculationControl),
    .readData1(readData1), .readData2(readData2), .immediateOperand(immediateOperand),
    .rs(rs), .rt(rt), .rdIn(rdIn),
    .memWbRegWrite(memWbRegWrite), .memWbRd(memWbRd), .memWbData(memWbData),
    .writeBackControlOut(writeBackControlOut), .memAccessControlOut(memAccessControlOut),
    .result(result), .writeData(writeData), .rdOut(rdOut),
    .stall(stall), .illegalOp(illegalOp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   wb;
    logic [1:0]   mem;
    logic [W-1:0] res;
    logic [W-1:0] wd;
    logic [4:0]   rd;
    logic         ill;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_total = 0;
  int   n_bad   = 0;

  function automatic exp_t observed();
    return {writeBackControlOut, memAccessControlOut, result, writeData, rdOut, illegalOp};
  endfunction

  function automatic logic [W:0] ref_exec(input logic [1:0] op, input logic [5:0] fn,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         bad;
    r   = '0;
    bad = 1'b0;
    if (op == 2'b00)      r = a + b;
    else if (op == 2'b01) r = a - b;
    else if (op == 2'b11) begin r = a + b; bad = 1'b1; end
    else begin
      case (fn)
        6'd0: r = a + b;
        6'd1: r = a - b;
        6'd2: r = a & b;
        6'd3: r = a | b;
        6'd4: r = a ^ b;
        6'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'd6: r = a << b[4:0];
        6'd7: r = a >> b[4:0];
`ifdef EXECUTE_MUL_EN
        6'd8: r = a * b;
`endif
        default: bad = 1'b1;
      endcase
    end
    return {bad, r};
  endfunction

  // Expected EX/MEM contents given the operand values the bench knows reach the ALU.
  function automatic exp_t model(input logic [1:0] wb, input logic [1:0] mem, input logic [3:0] cc,
                                 input logic [W-1:0] a, input logic [W-1:0] rtv,
                                 input logic [W-1:0] imm, input logic [4:0] t, input logic [4:0] d);
    logic [W:0] r;
    r = ref_exec(cc[2:1], imm[5:0], a, cc[0] ? imm : rtv);
    return {wb, mem, r[W-1:0], rtv, (cc[3] ? d : t), r[W]};
  endfunction

  task automatic drive(input logic [1:0] wb, input logic [1:0] mem, input logic [3:0] cc,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] imm,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    writeBackControlIn = wb;
    memAccessControlIn = mem;
    calculationControl = cc;
    readData1 = a;
    readData2 = b;
    immediateOperand = imm;
    rs = s;
    rt = t;
    rdIn = d;
  endtask

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    memWbRegWrite = 1'b0;
    memWbRd = '0;
    memWbData = '0;
    drive(2'b00, 2'b00, 4'h0, '0, '0, '0, 5'd0, 5'd0, 5'd0);
    @(posedge clk);
    @(posedge clk);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    @(posedge clk);
    drive(2'b11, 2'b11, 4'b0100, 32'd5, 32'd6, 32'd8, 5'd1, 5'd2, 5'd3);
    #1;
    n_total++;
    if (observed() !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", observed()); end
    n_total++;
    if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    @(posedge clk);
    reset = 1'b0;
    drive(2'b11, 2'b10, 4'b1000, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd3);
    tick();
    #2 reset = 1'b1;
    #1;
    n_total++;
    if (observed() !== '0) begin n_bad++; $display("FAIL reset_async: got %h want 0", observed()); end
    tick();
    n_total++;
    if (observed() !== '0) begin n_bad++; $display("FAIL reset_hold: got %h want 0", observed()); end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    do_reset();
    for (int i = 0; i < 30; i++) begin
      logic [1:0]   op;
      logic [5:0]   fn;
      logic [3:0]   cc;
      logic [W-1:0] a, b, imm;
      logic [1:0]   mem;
      logic [4:0]   s, t, d;
      op  = 2'($urandom_range(0, 3));
      fn  = 6'($urandom_range(0, 7));
      cc  = {1'($urandom_range(0, 1)), op, 1'($urandom_range(0, 1))};
      a   = $urandom();
      b   = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom();
      imm = $urandom();
      imm[5:0] = fn;
      mem = 2'($urandom_range(0, 3));
      s   = 5'($urandom_range(0, 31));
      t   = 5'($urandom_range(0, 31));
      d   = 5'($urandom_range(0, 31));
      drive({1'b0, 1'($urandom_range(0, 1))}, mem, cc, a, b, imm, s, t, d);
      sb.push_back(model(writeBackControlIn, mem, cc, a, b, imm, t, d));
      tick();
      e = sb.pop_front();
      n_total++;
      if (observed() !== e) begin
        n_bad++;
        $display("FAIL alu[%0d] cc=%h: got %h want %h", i, cc, observed(), e);
      end
    end
  endtask

  task automatic test_forward();
    do_reset();
    drive(2'b10, 2'b00, 4'b1000, 32'd5, 32'd0, 32'd0, 5'd0, 5'd0, 5'd3);
    sb.push_back({2'b10, 2'b00, 32'd5, 32'd0, 5'd3, 1'b0});
    tick();
    e = sb.pop_front();
    n_total++;
    if (observed() !== e) begin n_bad++; $display("FAIL fwd_setup: got %h want %h", observed(), e); end

    memWbRegWrite = 1'b1; memWbRd = 5'd3; memWbData = 32'd9;
    drive(2'b10, 2'b00, 4'b1000, 32'd100, 32'd200, 32'd0, 5'd3, 5'd3, 5'd7);
    sb.push_back({2'b10, 2'b00, 32'd10, 32'd5, 5'd7, 1'b0});
    tick();
    e = sb.pop_front();
    n_total++;
    if (observed() !== e) begin n_bad++; $display("FAIL fwd_exmem_prio: got %h want %h", observed(), e); end

    drive(2'b00, 2'b01, 4'b0000, 32'd100, 32'd200, 32'd0, 5'd3, 5'd7, 5'd1);
    sb.push_back({2'b00, 2'b01, 32'd19, 32'd10, 5'd7, 1'b0});
    tick();
    e = sb.pop_front();
    n_total++;
    if (observed() !== e) begin n_bad++; $display("FAIL fwd_mixed: got %h want %h", observed(), e); end

    drive(2'b10, 2'b00, 4'b1000, 32'd50, 32'd0, 32'd0, 5'd1, 5'd1, 5'd0);
    sb.push_back({2'b10, 2'b00, 32'd50, 32'd0, 5'd0, 1'b0});
    tick();
    e = sb.pop_front();
    n_total++;
    if (observed() !== e) begin n_bad++; $display("FAIL fwd_r0_setup: got %h want %h", observed(), e); end

    memWbRd = 5'd0; memWbData = 32'd77;
    drive(2'b00, 2'b00, 4'b0001, 32'd4, 32'd88, 32'd1, 5'd0, 5'd0, 5'd2);
    sb.push_back({2'b00, 2'b00, 32'd5, 32'd88, 5'd0, 1'b0});
    tick();
    e = sb.pop_front();
    n_total++;
    if (observed() !== e) begin n_bad++; $display("FAIL fwd_r0: got %h want %h", observed(), e); end
    memWbRegWrite = 1'b0;
  endtask

  task automatic test_illegal();
    do_reset();
    drive(2'b01, 2'b00, 4'b0100, 32'd3, 32'd4, 32'h3F, 5'd1, 5'd2, 5'd3);
    sb.push_back({2'b01, 2'b00, 32'd0, 32'd4, 5'd2, 1'b1});
    tick();
    e = sb.pop_front();
    n_total++;
    if (observed() !== e) begin n_bad++; $display("FAIL illegal_funct: got %h want %h", observed(), e); end

    drive(2'b00, 2'b00, 4'b0110, 32'd3, 32'd4, 32'd0, 5'd1, 5'd2, 5'd3);
    sb.push_back({2'b00, 2'b00, 32'd7, 32'd4, 5'd2, 1'b1});
    tick();
    e = sb.pop_front();
    n_total++;
    if (observed() !== e) begin n_bad++; $display("FAIL illegal_aluop: got %h want %h", observed(), e); end

    drive(2'b00, 2'b00, 4'b0000, 32'd3, 32'd4, 32'd0, 5'd1, 5'd2, 5'd3);
    sb.push_back({2'b00, 2'b00, 32'd7, 32'd4, 5'd2, 1'b0});
    tick();
    e = sb.pop_front();
    n_total++;
    if (observed() !== e) begin n_bad++; $display("FAIL illegal_clears: got %h want %h", observed(), e); end

`ifndef EXECUTE_MUL_EN
    drive(2'b10, 2'b00, 4'b0100, 32'd7, 32'd6, 32'd8, 5'd1, 5'd2, 5'd3);
    sb.push_back({2'b10, 2'b00, 32'd0, 32'd6, 5'd2, 1'b1});
    #1;
    n_total++;
    if (stall !== 1'b0) begin n_bad++; $display("FAIL nomul_stall: got %b want 0", stall); end
    tick();
    e = sb.pop_front();
    n_total++;
    if (observed() !== e) begin n_bad++; $display("FAIL nomul_funct8: got %h want %h", observed(), e); end
    n_total++;
    if (stall !== 1'b0) begin n_bad++; $display("FAIL nomul_stall2: got %b want 0", stall); end
`endif
  endtask

  task automatic test_flush();
    do_reset();
    flush = 1'b1;
    drive(2'b11, 2'b11, 4'b1110, 32'd3, 32'd4, 32'd0, 5'd1, 5'd2, 5'd3);
    tick();
    n_total++;
    if ({writeBackControlOut, memAccessControlOut, illegalOp} !== 5'b0) begin
      n_bad++;
      $display("FAIL flush_bubble: got %b want 00000", {writeBackControlOut, memAccessControlOut, illegalOp});
    end
    flush = 1'b0;
  endtask

`ifdef EXECUTE_MUL_EN
  task automatic test_mul();
    logic [W-1:0] ma[2];
    logic [W-1:0] mb[2];
    logic [W-1:0] mp[2];
    ma[0] = 32'd7;        mb[0] = 32'd6; mp[0] = 32'd42;
    ma[1] = 32'hFFFFFFFF; mb[1] = 32'd2; mp[1] = 32'hFFFFFFFE;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      int n_stall;
      n_stall = 0;
      drive(2'b11, 2'b01, 4'b1100, ma[c], mb[c], 32'd8, 5'd1, 5'd2, 5'd9);
      sb.push_back({2'b11, 2'b01, mp[c], mb[c], 5'd9, 1'b0});
      for (int k = 0; k < 40; k++) begin
        #1;
        if (!stall) break;
        n_stall++;
        tick();
        n_total++;
        if ({writeBackControlOut, memAccessControlOut} !== 4'b0) begin
          n_bad++;
          $display("FAIL mul_bubble[%0d] cyc %0d: got %b want 0000", c, k, {writeBackControlOut, memAccessControlOut});
        end
      end
      n_total++;
      if (n_stall != 32) begin n_bad++; $display("FAIL mul_stall_cycles[%0d]: got %0d want 32", c, n_stall); end
      tick();
      e = sb.pop_front();
      n_total++;
      if (observed() !== e) begin n_bad++; $display("FAIL mul_result[%0d]: got %h want %h", c, observed(), e); end
    end
  endtask

  task automatic test_mul_flush();
    do_reset();
    drive(2'b11, 2'b01, 4'b1100, 32'd7, 32'd6, 32'd8, 5'd1, 5'd2, 5'd9);
    for (int k = 0; k < 10; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(2'b00, 2'b00, 4'b0000, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    n_total++;
    if ({writeBackControlOut, memAccessControlOut, illegalOp} !== 5'b0) begin
      n_bad++;
      $display("FAIL mulflush_bubble: got %b want 00000", {writeBackControlOut, memAccessControlOut, illegalOp});
    end
    #1;
    n_total++;
    if (stall !== 1'b0) begin n_bad++; $display("FAIL mulflush_stall: got %b want 0", stall); end
    drive(2'b10, 2'b00, 4'b1000, 32'd2, 32'd3, 32'd0, 5'd4, 5'd5, 5'd6);
    sb.push_back({2'b10, 2'b00, 32'd5, 32'd3, 5'd6, 1'b0});
    tick();
    e = sb.pop_front();
    n_total++;
    if (observed() !== e) begin n_bad++; $display("FAIL mulflush_idle: got %h want %h", observed(), e); end
  endtask

  task automatic test_reset_mid_mul();
    do_reset();
    drive(2'b11, 2'b01, 4'b1100, 32'd7, 32'd6, 32'd8, 5'd1, 5'd2, 5'd9);
    for (int k = 0; k < 5; k++) tick();
    #2 reset = 1'b1;
    #1;
    n_total++;
    if (observed() !== '0) begin n_bad++; $display("FAIL midmul_reset_out: got %h want 0", observed()); end
    n_total++;
    if (stall !== 1'b0) begin n_bad++; $display("FAIL midmul_reset_stall: got %b want 0", stall); end
    @(posedge clk);
    reset = 1'b0;
    drive(2'b10, 2'b00, 4'b1000, 32'd1, 32'd1, 32'd0, 5'd3, 5'd3, 5'd4);
    for (int k = 0; k < 34; k++) begin
      sb.push_back({2'b10, 2'b00, 32'd2, 32'd1, 5'd4, 1'b0});
      tick();
      e = sb.pop_front();
      n_total++;
      if (observed() !== e || stall !== 1'b0) begin
        n_bad++;
        $display("FAIL midmul_add[%0d]: got %h stall %b want %h stall 0", k, observed(), stall, e);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_forward();
    test_illegal();
    test_flush();
`ifdef EXECUTE_MUL_EN
    test_mul();
    test_mul_flush();
    test_reset_mid_mul();
`endif
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
